truth_table_extractor: RTL
==========================

Name: truth_table_extractor

Overview:
Sequential reader that characterises a combinational N-input logic gate under test (GUT) and recovers its truth-table hex code, e.g. 0x80 for NOR3.
- Drives every input combination in ascending binary order.
- Waits a programmable settle time after each change, then samples the GUT output.
- Packs the samples MSB-first, so row 000 maps to the MSB.
- Sits in the design-validation harness beside the synthesised logic netlists and feeds their regression checks.

Parameters:
- N_INPUTS, 3, number of GUT inputs; legal range 1..4.
- SETTLE_CYCLES, 4, clock cycles stim is held before sampling; must be at least 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a sweep; accepted only in IDLE.
- stim  output  N_INPUTS  applied to the GUT as {in1,in2,...}; bit N_INPUTS-1 = in1.
- gut_out  input  1  GUT output; sampled synchronously.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when a sweep completes.
- valid  output  1  truth_table holds a completed result.
- truth_table  output  2**N_INPUTS  extracted code.

Behaviour:
- Reset values: stim=0, busy=0, done=0, valid=0, truth_table=0, state=IDLE, row=0, internal shadow register=0.
- Reset asserted mid-sweep aborts the sweep immediately to these values. No partial result is published.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 → SETTLE.
  - On that edge: row<=0, stim<=0, cnt<=SETTLE_CYCLES-1, valid<=0.
- SETTLE:
  - busy=1.
  - cnt!=0 → cnt decrements.
  - cnt==0 → SAMPLE.
  - Occupies exactly SETTLE_CYCLES cycles per row.
- SAMPLE:
  - shadow[2**N_INPUTS-1-row] <= gut_out.
  - Last row (row==2**N_INPUTS-1) → DONE.
  - Otherwise row<=row+1, stim<=row+1, cnt reloads, → SETTLE.
- DONE (one cycle):
  - done=1, busy=0.
  - truth_table<=shadow, valid<=1.
  - → IDLE.
- Latency: with start accepted at cycle 0, done is high at cycle 2**N_INPUTS*(SETTLE_CYCLES+1)+1. Defaults give 41.
- stim changes only on SETTLE entry. It is held constant through SETTLE and SAMPLE, and holds the last row value after completion.
- start while busy or in DONE is ignored; it is not queued.
- start held high continuously launches a new sweep on the first IDLE cycle.
- valid stays high and truth_table stays stable until the next accepted start clears valid.
- Row counter width is N_INPUTS+1; it never wraps within a sweep.

Optional Feature:
- Macro: TRUTH_TABLE_EXPECT_EN.
- When defined, adds two ports:
  - expected  input  2**N_INPUTS  reference code, sampled in DONE.
  - match  output  1  set in DONE to (shadow==expected); reset 0; cleared on accepted start.
- When undefined: neither port exists, and the rest of the behaviour is identical.

Decomposition:
- Package tt_pkg:
  - state enum (IDLE, SETTLE, SAMPLE, DONE).
  - function tt_width(n) returning 2**n.
  - localparam MAX_INPUTS=4.
- One sub-module, tt_settle_timer:
  - loadable down-counter; ports load, load_val, zero.
  - instantiated once for the SETTLE countdown.

Test Plan:
- NOR3 model (out=~(in1|in2|in3)), defaults, start at cycle 0 → done pulse at cycle 41, truth_table=8'h80, valid=1, busy=0.
- AND3 model → 8'h01. Constant-1 model → 8'hFF. Stim sequence observed as 0..7, each value held 5 cycles.
- Model with 3-cycle output delay, SETTLE_CYCLES=4 → correct code. Same model with SETTLE_CYCLES=1 → corrupted code, proving the settle timing matters.
- start pulsed at cycle 10 during a sweep → ignored; single done at cycle 41; result unchanged.
- rst asserted at cycle 20, released at cycle 22 → all outputs 0, state IDLE. A new start yields a correct 8'h80 after 41 cycles; no stale bits from the aborted sweep.
- TRUTH_TABLE_EXPECT_EN defined, NOR3 model:
  - expected=8'h80 → match=1.
  - expected=8'h7F → match=0.
  - match clears on the next start.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table extractor.
package tt_pkg;

  // Largest GUT fan-in the extractor supports.
  localparam int MAX_INPUTS = 4;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_e;

  // Number of truth-table rows (and code bits) for an n-input gate.
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that measures the settle interval for each row.
// zero is asserted while the count is 0; counting stops there.
module tt_settle_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: load takes priority, otherwise decrement toward zero when enabled.
  always_comb begin
    // NOTE: assign a default first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state flops use non-blocking assignments so all flops update together.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps every input combination of a combinational gate under test,
// waits a settle interval per row, samples the gate output and packs the
// samples MSB-first (row 0 -> MSB) into a truth-table code.
// Optional feature: define TRUTH_TABLE_EXPECT_EN to add the expected/match
// ports that compare the extracted code against a reference.
module truth_table_extractor
  import tt_pkg::*;
#(
  parameter int N_INPUTS      = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic [N_INPUTS-1:0]           stim,
  input  logic                          gut_out,
  output logic                          busy,
  output logic                          done,
  output logic                          valid,
  output logic [tt_width(N_INPUTS)-1:0] truth_table
`ifdef TRUTH_TABLE_EXPECT_EN
  ,
  input  logic [tt_width(N_INPUTS)-1:0] expected,
  output logic                          match
`endif
);

  localparam int W  = tt_width(N_INPUTS);
  localparam int RW = N_INPUTS + 1;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [RW-1:0] LAST_ROW   = RW'(W - 1);
  localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES - 1);

  tt_state_e           state_q,  state_d;
  logic [RW-1:0]       row_q,    row_d;
  logic [N_INPUTS-1:0] stim_q,   stim_d;
  logic                busy_q,   busy_d;
  logic                done_q,   done_d;
  logic                valid_q,  valid_d;
  logic [W-1:0]        tt_q,     tt_d;
  logic [W-1:0]        shadow_q, shadow_d;
`ifdef TRUTH_TABLE_EXPECT_EN
  logic                match_q,  match_d;
`endif

  logic                timer_load;
  logic                timer_en;
  logic                timer_zero;
  logic [RW-1:0]       row_nxt;
  logic [N_INPUTS-1:0] bit_idx;

  assign row_nxt = row_q + RW'(1);
  // Row r lands at bit W-1-r, which is simply the bitwise complement of r.
  assign bit_idx = ~row_q[N_INPUTS-1:0];

  tt_settle_timer #(
    .WIDTH (CW)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .en       (timer_en),
    .load_val (SETTLE_MAX),
    .zero     (timer_zero)
  );

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    stim_d     = stim_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    valid_d    = valid_q;
    tt_d       = tt_q;
    shadow_d   = shadow_q;
`ifdef TRUTH_TABLE_EXPECT_EN
    match_d    = match_q;
`endif
    timer_load = 1'b0;
    timer_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SETTLE;
          row_d      = '0;
          stim_d     = '0;
          busy_d     = 1'b1;
          valid_d    = 1'b0;
          timer_load = 1'b1;
`ifdef TRUTH_TABLE_EXPECT_EN
          match_d    = 1'b0;
`endif
        end
      end
      SETTLE: begin
        if (timer_zero) begin
          state_d = SAMPLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      SAMPLE: begin
        shadow_d[bit_idx] = gut_out;
        if (row_q == LAST_ROW) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d    = SETTLE;
          row_d      = row_nxt;
          stim_d     = row_nxt[N_INPUTS-1:0];
          timer_load = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        tt_d    = shadow_q;
        valid_d = 1'b1;
`ifdef TRUTH_TABLE_EXPECT_EN
        match_d = (shadow_q == expected);
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any sweep without publishing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      stim_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      tt_q     <= '0;
      shadow_q <= '0;
`ifdef TRUTH_TABLE_EXPECT_EN
      match_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      stim_q   <= stim_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      tt_q     <= tt_d;
      shadow_q <= shadow_d;
`ifdef TRUTH_TABLE_EXPECT_EN
      match_q  <= match_d;
`endif
    end
  end

  assign stim        = stim_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign valid       = valid_q;
  assign truth_table = tt_q;
`ifdef TRUTH_TABLE_EXPECT_EN
  assign match       = match_q;
`endif

endmodule
